bus_grant_arbiter: RTL and testbench
====================================

Name: bus_grant_arbiter

Overview:
- Round-robin arbiter that generates the one-hot bus_grant inputs for every data_bus_device on the shared tri-state data bus.
- Sits directly upstream of the bus devices and replaces the manual grant pins.
- Holds a grant for the duration of a transfer.
- Forces rotation after MAX_HOLD cycles when other devices are waiting.
- Inserts a one-cycle turnaround between owners so two drivers never overlap on the bus.

Parameters:
- NUM_REQ, 4: number of requesting bus devices; must be >= 2.
- MAX_HOLD, 16: cycles an owner may hold the bus while others request; 0 disables forced rotation.
- ID_W, $clog2(NUM_REQ): width of grant_id.

Ports:
- clk, input, 1: system clock; all logic on the rising edge.
- rst, input, 1: synchronous active-high reset.
- req, input, NUM_REQ: per-device bus request; bit i is device i.
- grant, output, NUM_REQ: one-hot registered grant; drives each device's bus_grant.
- grant_id, output, ID_W: index of the current owner; valid only while busy=1.
- busy, output, 1: high while any grant bit is high.
- turnaround, output, 1: high during the dead cycle between owners.

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high.
- Reset values: grant=0, grant_id=0, busy=0, turnaround=0, state=IDLE, priority pointer=0, hold counter=0.
- Outputs: all registered. grant has at most one bit set in every cycle, including across reset.
- States: IDLE, GRANT, TURN.
- Arbitration function: selects the first i with req[i]=1, searching cyclically from pointer upward and wrapping NUM_REQ-1 -> 0.
- IDLE:
  - If req != 0, arbitrate. Next cycle: state=GRANT, grant=onehot(winner), grant_id=winner, busy=1, hold counter=1.
  - Latency: req sampled at edge N gives grant visible after edge N+1, i.e. one cycle.
  - If req = 0, stay in IDLE.
- GRANT, owner o:
  - If req[o]=0, release. Next cycle: grant=0, busy=0, turnaround=1, state=TURN, pointer=(o+1) mod NUM_REQ.
  - Else if MAX_HOLD!=0 and hold counter >= MAX_HOLD and (req with bit o masked) != 0, preempt. Same next-cycle update as release.
  - Else stay in GRANT. Hold counter increments and saturates at MAX_HOLD.
  - A sole requester keeps the bus indefinitely, with no gaps.
- TURN:
  - Lasts exactly one cycle. turnaround=1, grant=0.
  - Arbitrate in this cycle using the updated pointer and the current req.
  - If req != 0, next cycle: GRANT to the winner, hold counter=1, turnaround=0. The previous owner may win again if it is the only requester.
  - Otherwise go to IDLE.
- Timing bounds: minimum gap between two different owners is 1 cycle; maximum wait for a requester is (NUM_REQ-1)*(MAX_HOLD+1) cycles.
- Simultaneous events:
  - Owner drop and a new req in the same cycle: the release wins, then normal TURN arbitration.
  - A req that rises during TURN is considered in that cycle's arbitration.
- Reset mid-operation: reset overrides everything. Next cycle all outputs are at reset values and pointer=0. An in-flight transfer is abandoned; no turnaround cycle is inserted.
- Request contract: req pulses shorter than one cycle are not captured. Dropping req is the device's only release mechanism.

Test Plan (NUM_REQ=4, MAX_HOLD=4):
1. Reset: rst=1 for 2 cycles with req=4'b1111 -> grant=0000, busy=0 throughout. First edge with rst=0 samples req; grant=0001 one cycle later, grant_id=0.
2. Single request: req=0100 from cycle 10 -> grant=0100, grant_id=2 from cycle 11. req drops at cycle 20 -> grant=0000 and turnaround=1 at cycle 21, IDLE at cycle 22.
3. Full contention: req=1111 held -> grant=0001 for 4 cycles, then 0000 for 1, then 0010 x4, 0000, 0100 x4, 0000, 1000 x4, 0000, then back to 0001. grant is never multi-hot.
4. Sole owner: req=0001 only for 20 cycles -> grant=0001 continuous for 20 cycles, no turnaround, counter saturated at 4. req becomes 0011 -> preempt on the next cycle, 1-cycle gap, then grant=0010.
5. Simultaneous release/request: owner 0 drops req[0] in the same cycle req[3] rises -> one turnaround cycle, then grant=1000, grant_id=3.
6. Reset mid-grant: grant=0100 active, assert rst for 1 cycle -> grant=0000 and busy=0 next cycle. With req=1111 after reset, the first grant is 0001 (pointer back to 0).

Source files
------------

// File: rtl/bus_grant_arbiter.sv
// -----------------------------------------------------------------------------
// bus_grant_arbiter
//
// Round-robin owner selection for the shared tri-state data bus. The arbiter
// drives the one-hot bus_grant pins of every data_bus_device. An owner keeps
// the bus for as long as it holds its request. When others are waiting, it is
// forced off after MAX_HOLD cycles. Every change of owner passes through one
// dead cycle, so two devices never drive the bus at the same time.
//
// Parameters
//   NUM_REQ   number of requesting devices (>= 2)
//   MAX_HOLD  cycles an owner may keep the bus while others request;
//             0 disables forced rotation
//   ID_W      width of grant_id
//
// Ports
//   clk        in   system clock, rising edge
//   rst        in   synchronous active-high reset
//   req        in   per-device bus request, bit i = device i
//   grant      out  registered one-hot grant (at most one bit set)
//   grant_id   out  index of the current owner, meaningful while busy=1
//   busy       out  high while a grant bit is high
//   turnaround out  high during the dead cycle between owners
// -----------------------------------------------------------------------------
module bus_grant_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int MAX_HOLD = 16,
  parameter int ID_W     = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_id,
  output logic               busy,
  output logic               turnaround
);

  // The hold counter only needs to reach MAX_HOLD, where it saturates.
  localparam int HOLD_W = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);

  localparam logic [HOLD_W-1:0]  HOLD_ZERO  = {HOLD_W{1'b0}};
  localparam logic [HOLD_W-1:0]  HOLD_ONE   = HOLD_W'(1);
  localparam logic [HOLD_W-1:0]  HOLD_LIMIT = HOLD_W'(MAX_HOLD);
  localparam logic [ID_W-1:0]    ID_ZERO    = {ID_W{1'b0}};
  localparam logic [ID_W-1:0]    ID_ONE     = ID_W'(1);
  localparam logic [ID_W-1:0]    ID_LAST    = ID_W'(NUM_REQ - 1);
  localparam logic [NUM_REQ-1:0] GRANT_NONE = {NUM_REQ{1'b0}};
  localparam logic [NUM_REQ-1:0] GRANT_ONE  = NUM_REQ'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_TURN  = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------

  // Cyclic search for the first active request, starting at the pointer.
  // Returns {found, index}.
  function automatic logic [ID_W:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                            input logic [ID_W-1:0]    p);
    logic            found;
    logic [ID_W-1:0] win;
    logic [ID_W-1:0] idx;
    found = 1'b0;
    win   = ID_ZERO;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = ID_W'((int'(p) + k) % NUM_REQ);
      if (!found && r[idx]) begin
        found = 1'b1;
        win   = idx;
      end else begin
        found = found;
      end
    end
    return {found, win};
  endfunction

  // One-hot vector for a device index.
  function automatic logic [NUM_REQ-1:0] onehot(input logic [ID_W-1:0] idx);
    return GRANT_ONE << idx;
  endfunction

  // Successor index, wrapping from the last device back to 0.
  function automatic logic [ID_W-1:0] next_idx(input logic [ID_W-1:0] idx);
    logic [ID_W-1:0] n;
    if (idx == ID_LAST) begin
      n = ID_ZERO;
    end else begin
      n = idx + ID_ONE;
    end
    return n;
  endfunction

  // ---------------------------------------------------------------------------
  // State and registered outputs
  // ---------------------------------------------------------------------------
  state_t              state_r;
  state_t              state_nxt_s;
  logic [ID_W-1:0]     ptr_r;
  logic [ID_W-1:0]     ptr_nxt_s;
  logic [HOLD_W-1:0]   hold_r;
  logic [HOLD_W-1:0]   hold_nxt_s;

  logic [NUM_REQ-1:0]  grant_r;
  logic [NUM_REQ-1:0]  grant_nxt_s;
  logic [ID_W-1:0]     grant_id_r;
  logic [ID_W-1:0]     grant_id_nxt_s;
  logic                busy_r;
  logic                busy_nxt_s;
  logic                turn_r;
  logic                turn_nxt_s;

  // Arbitration and ownership decisions shared by both combinational blocks
  logic [ID_W:0]       pick_s;
  logic                pick_found_s;
  logic [ID_W-1:0]     pick_idx_s;
  logic                owner_req_s;
  logic                others_req_s;
  logic                hold_expired_s;
  logic                release_s;

  assign pick_s       = rr_pick(req, ptr_r);
  assign pick_found_s = pick_s[ID_W];
  assign pick_idx_s   = pick_s[ID_W-1:0];

  // The owner is the registered grant_id; in GRANT it always matches grant_r.
  assign owner_req_s    = req[grant_id_r];
  assign others_req_s   = |(req & ~grant_r);
  assign hold_expired_s = (MAX_HOLD != 0) && (hold_r >= HOLD_LIMIT);

  // A dropped request releases the bus. A request that is still held is
  // preempted only once the hold budget is spent and someone else is waiting.
  assign release_s = !owner_req_s || (hold_expired_s && others_req_s);

  // State register, priority pointer and hold counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      ptr_r   <= ID_ZERO;
      hold_r  <= HOLD_ZERO;
    end else begin
      state_r <= state_nxt_s;
      ptr_r   <= ptr_nxt_s;
      hold_r  <= hold_nxt_s;
    end
  end

  // Next-state, pointer and hold-counter logic
  always_comb begin
    state_nxt_s = state_r;
    ptr_nxt_s   = ptr_r;
    hold_nxt_s  = hold_r;
    case (state_r)
      ST_IDLE: begin
        if (pick_found_s) begin
          state_nxt_s = ST_GRANT;
          hold_nxt_s  = HOLD_ONE;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_GRANT: begin
        if (release_s) begin
          // The owner moves to the back of the queue for the next search
          state_nxt_s = ST_TURN;
          ptr_nxt_s   = next_idx(grant_id_r);
          hold_nxt_s  = HOLD_ZERO;
        end else if (hold_r < HOLD_LIMIT) begin
          hold_nxt_s  = hold_r + HOLD_ONE;
        end else begin
          hold_nxt_s  = hold_r;
        end
      end
      ST_TURN: begin
        // The previous owner may win again here if it is the only requester
        if (pick_found_s) begin
          state_nxt_s = ST_GRANT;
          hold_nxt_s  = HOLD_ONE;
        end else begin
          state_nxt_s = ST_IDLE;
          hold_nxt_s  = HOLD_ZERO;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        ptr_nxt_s   = ID_ZERO;
        hold_nxt_s  = HOLD_ZERO;
      end
    endcase
  end

  // Next values for the registered outputs, decided from the current state
  always_comb begin
    grant_nxt_s    = grant_r;
    grant_id_nxt_s = grant_id_r;
    busy_nxt_s     = busy_r;
    turn_nxt_s     = 1'b0;
    case (state_r)
      ST_IDLE, ST_TURN: begin
        if (pick_found_s) begin
          grant_nxt_s    = onehot(pick_idx_s);
          grant_id_nxt_s = pick_idx_s;
          busy_nxt_s     = 1'b1;
        end else begin
          grant_nxt_s    = GRANT_NONE;
          grant_id_nxt_s = ID_ZERO;
          busy_nxt_s     = 1'b0;
        end
      end
      ST_GRANT: begin
        if (release_s) begin
          // Drop the grant for one dead cycle before any new owner
          grant_nxt_s    = GRANT_NONE;
          grant_id_nxt_s = ID_ZERO;
          busy_nxt_s     = 1'b0;
          turn_nxt_s     = 1'b1;
        end else begin
          grant_nxt_s    = grant_r;
          grant_id_nxt_s = grant_id_r;
          busy_nxt_s     = 1'b1;
        end
      end
      default: begin
        grant_nxt_s    = GRANT_NONE;
        grant_id_nxt_s = ID_ZERO;
        busy_nxt_s     = 1'b0;
      end
    endcase
  end

  // Output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      grant_r    <= GRANT_NONE;
      grant_id_r <= ID_ZERO;
      busy_r     <= 1'b0;
      turn_r     <= 1'b0;
    end else begin
      grant_r    <= grant_nxt_s;
      grant_id_r <= grant_id_nxt_s;
      busy_r     <= busy_nxt_s;
      turn_r     <= turn_nxt_s;
    end
  end

  assign grant      = grant_r;
  assign grant_id   = grant_id_r;
  assign busy       = busy_r;
  assign turnaround = turn_r;

endmodule

// File: tb/tb_bus_grant_arbiter.sv
// -----------------------------------------------------------------------------
// tb_bus_grant_arbiter
//
// Directed bench for bus_grant_arbiter (NUM_REQ=4, MAX_HOLD=4). Each stimulus
// cycle pushes the hand-computed outputs expected after the next clock edge.
// A separate monitor pops one entry per cycle and compares it with the DUT on
// the falling edge.
// -----------------------------------------------------------------------------
module tb_bus_grant_arbiter;

  localparam int NUM_REQ  = 4;
  localparam int MAX_HOLD = 4;
  localparam int ID_W     = 2;

  logic               clk = 1'b0;
  logic               rst;
  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    grant_id;
  logic               busy;
  logic               turnaround;

  always #5 clk = ~clk;

  bus_grant_arbiter #(
    .NUM_REQ  (NUM_REQ),
    .MAX_HOLD (MAX_HOLD),
    .ID_W     (ID_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .grant      (grant),
    .grant_id   (grant_id),
    .busy       (busy),
    .turnaround (turnaround)
  );

  typedef struct packed {
    logic [3:0] grant;
    logic [1:0] id;
    logic       busy;
    logic       turn;
    logic       chk_id;
    logic [7:0] tn;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string nm, input int tn, input logic [31:0] act,
                     input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s (test %0d) at %0t: got %0h, expected %0h",
               nm, tn, $time, act, expv);
    end
  endtask

  // Monitor: one expected entry per clock, compared on the falling edge
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("grant", int'(e.tn), 32'(grant), 32'(e.grant));
        chk("busy", int'(e.tn), 32'(busy), 32'(e.busy));
        chk("turnaround", int'(e.tn), 32'(turnaround), 32'(e.turn));
        chk("onehot", int'(e.tn), 32'($countones(grant) <= 1), 32'(1));
        if (e.chk_id) begin
          chk("grant_id", int'(e.tn), 32'(grant_id), 32'(e.id));
        end
      end
    end
  end

  // Drive one cycle of inputs and record the outputs expected after the edge
  task automatic step(input logic r, input logic [3:0] rq, input logic [3:0] g,
                      input logic [1:0] id, input logic b, input logic t,
                      input logic ci, input int tn);
    exp_t e;
    rst = r;
    req = rq;
    @(posedge clk);
    e.grant  = g;
    e.id     = id;
    e.busy   = b;
    e.turn   = t;
    e.chk_id = ci;
    e.tn     = 8'(tn);
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic gnt(input logic [3:0] rq, input logic [3:0] g, input int id,
                     input int tn);
    step(1'b0, rq, g, 2'(id), 1'b1, 1'b0, 1'b1, tn);
  endtask

  task automatic turn(input logic [3:0] rq, input int tn);
    step(1'b0, rq, 4'b0000, 2'd0, 1'b0, 1'b1, 1'b0, tn);
  endtask

  task automatic idle(input logic [3:0] rq, input int tn);
    step(1'b0, rq, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0, tn);
  endtask

  initial begin
    // 1: reset held two cycles with all requests up
    step(1'b1, 4'b1111, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b1, 1);
    step(1'b1, 4'b1111, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b1, 1);

    // 3: full contention, 4 grant cycles then a dead cycle per device
    for (int d = 0; d < 4; d++) begin
      for (int k = 0; k < 4; k++) begin
        gnt(4'b1111, 4'b0001 << d, d, 3);
      end
      turn(4'b1111, 3);
    end
    gnt(4'b1111, 4'b0001, 0, 3);
    turn(4'b0000, 3);
    idle(4'b0000, 3);                 // pointer now 1

    // 2: single requester holds, then releases
    for (int k = 0; k < 10; k++) begin
      gnt(4'b0100, 4'b0100, 2, 2);
    end
    turn(4'b0000, 2);
    idle(4'b0000, 2);                 // pointer now 3

    // 4: sole owner never preempted, then preempted once device 1 asks
    for (int k = 0; k < 20; k++) begin
      gnt(4'b0001, 4'b0001, 0, 4);
    end
    turn(4'b0011, 4);
    gnt(4'b0011, 4'b0010, 1, 4);
    gnt(4'b0011, 4'b0010, 1, 4);
    turn(4'b0000, 4);
    idle(4'b0000, 4);                 // pointer now 2

    // 5: owner 0 drops in the same cycle device 3 raises
    gnt(4'b0001, 4'b0001, 0, 5);
    gnt(4'b0001, 4'b0001, 0, 5);
    turn(4'b1000, 5);
    gnt(4'b1000, 4'b1000, 3, 5);
    gnt(4'b1000, 4'b1000, 3, 5);

    // 7: request re-raised during the dead cycle; previous owner wins again
    turn(4'b0000, 7);
    gnt(4'b1000, 4'b1000, 3, 7);
    gnt(4'b1000, 4'b1000, 3, 7);
    turn(4'b0000, 7);
    idle(4'b0000, 7);                 // pointer now 0

    // 6: reset in the middle of a grant, pointer returns to 0
    gnt(4'b0100, 4'b0100, 2, 6);
    gnt(4'b0100, 4'b0100, 2, 6);
    step(1'b1, 4'b1111, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b1, 6);
    gnt(4'b1111, 4'b0001, 0, 6);
    gnt(4'b1111, 4'b0001, 0, 6);
    turn(4'b0000, 6);
    idle(4'b0000, 6);

    @(negedge clk);
    chk("drain", 0, 32'(exp_q.size()), 32'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
